// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared header for the keypad scanner and the watch/stopwatch block that
// consumes its key codes.
//   KEY_STAR / KEY_HASH : codes for the '*' and '#' keys
//   scanState_t         : scanner FSM state encoding
//   keyCode()           : row/column position -> 4-bit key code
//   colDrive()          : column index -> active-low column drive pattern
//   rowDecode()         : synchronized row pattern -> {exactly-one-low, row index}
// ---------------------------------------------------------------------------
package keypad_pkg;

   localparam logic [3:0] KEY_STAR = 4'hE;
   localparam logic [3:0] KEY_HASH = 4'hF;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } scanState_t;

   // Phone layout: rows 0-2 hold the digits 1-9 left to right, row 3 is * 0 #.
   // Column index 3 never occurs in operation and is treated as column 0.
   function automatic logic [3:0] keyCode(input logic [1:0] rowIdx, input logic [1:0] colIdx);
      logic [3:0] col;
      col = (colIdx == 2'd3) ? 4'd0 : {2'b00, colIdx};
      case (rowIdx)
         2'd0:    return 4'd1 + col;
         2'd1:    return 4'd4 + col;
         2'd2:    return 4'd7 + col;
         default: begin
            case (col)
               4'd0:    return KEY_STAR;
               4'd1:    return 4'd0;
               default: return KEY_HASH;
            endcase
         end
      endcase
   endfunction

   // Exactly one column is pulled low at any time; index 3 falls back to column 0.
   function automatic logic [2:0] colDrive(input logic [1:0] colIdx);
      case (colIdx)
         2'd1:    return 3'b101;
         2'd2:    return 3'b011;
         default: return 3'b110;
      endcase
   endfunction

   // Bit 2 flags a clean single-row hit; bits 1:0 carry that row's index.
   // Patterns with no row or several rows low are reported as no hit.
   function automatic logic [2:0] rowDecode(input logic [3:0] rows);
      case (rows)
         4'b1110: return 3'b100;
         4'b1101: return 3'b101;
         4'b1011: return 3'b110;
         4'b0111: return 3'b111;
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a bundle of slow, independently changing inputs.
// Resets to all-ones so pulled-up (active-low) inputs look idle out of reset.
//   clk    : destination clock
//   rst    : asynchronous, active-high reset
//   data_i : asynchronous input bits
//   data_o : synchronized copy, two clk cycles behind data_i
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] stage1_q;
   logic [WIDTH-1:0] stage2_q;

   // First flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage1_q <= '1;
         stage2_q <= '1;
      end else begin
         stage1_q <= data_i;
         stage2_q <= stage1_q;
      end
   end

   assign data_o = stage2_q;

endmodule

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// Scans a 3x4 phone keypad one column at a time, debounces presses and
// releases, and hands each accepted key to the watch block as a 4-bit code
// with a single-cycle strobe. One clk cycle is 1 ms.
//   clk          : 1 kHz system clock
//   rst          : asynchronous, active-high reset
//   key_row      : keypad rows, active-low, asynchronous to clk
//   key_col      : column drive, active-low, exactly one column low
//   keypad_input : last accepted key code (0-9, KEY_STAR, KEY_HASH)
//   keypad_valid : one-cycle strobe, keypad_input valid in the same cycle
//   key_held     : high from the strobe until the release is debounced
// Parameters:
//   DEBOUNCE : cycles a row pattern must stay stable (>= 2)
//   SETTLE   : cycles each column is driven before sampling (>= 3)
// ---------------------------------------------------------------------------
module keypad_scanner #(
   parameter int DEBOUNCE = 20,
   parameter int SETTLE   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key_row,
   output logic [2:0] key_col,
   output logic [3:0] keypad_input,
   output logic       keypad_valid,
   output logic       key_held
);

   import keypad_pkg::*;

   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam int SET_W = $clog2(SETTLE + 1);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);

   scanState_t       state_q;
   logic [1:0]       colIdx_q;
   logic [SET_W-1:0] settleCnt_q;
   logic [CNT_W-1:0] dbCnt_q;
   logic [3:0]       rowPat_q;
   logic [1:0]       rowIdx_q;
   logic [3:0]       keyCode_q;
   logic             valid_q;
   logic             held_q;

   logic [3:0]       rowSync;
   logic [2:0]       rowInfo;
   logic             rowHit;
   logic [CNT_W-1:0] dbCntInc;

   sync_2ff #(
      .WIDTH (4)
   ) uRowSync (
      .clk    (clk),
      .rst    (rst),
      .data_i (key_row),
      .data_o (rowSync)
   );

   assign rowInfo  = rowDecode(rowSync);
   assign rowHit   = rowInfo[2];

   // The debounce counter saturates at DEBOUNCE so it can never wrap back to
   // a small value and retrigger a strobe.
   assign dbCntInc = (dbCnt_q == DB_MAX) ? dbCnt_q : dbCnt_q + 1'b1;

   // Scanner FSM. The column only moves in SCAN; every other state keeps the
   // column that found the key so the row lines keep reflecting that key.
   // Leaving DEBOUNCE or RELEASE back to SCAN restarts the settle window on
   // the same column rather than skipping ahead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SCAN;
         colIdx_q    <= 2'd0;
         settleCnt_q <= '0;
         dbCnt_q     <= '0;
         rowPat_q    <= 4'hF;
         rowIdx_q    <= 2'd0;
         keyCode_q   <= 4'h0;
         valid_q     <= 1'b0;
         held_q      <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            ST_SCAN: begin
               if (settleCnt_q == SET_LAST) begin
                  settleCnt_q <= '0;
                  if (rowHit) begin
                     rowPat_q <= rowSync;
                     rowIdx_q <= rowInfo[1:0];
                     dbCnt_q  <= '0;
                     state_q  <= ST_DEBOUNCE;
                  end else begin
                     colIdx_q <= (colIdx_q >= 2'd2) ? 2'd0 : colIdx_q + 2'd1;
                  end
               end else begin
                  settleCnt_q <= settleCnt_q + 1'b1;
               end
            end

            ST_DEBOUNCE: begin
               if (rowSync != rowPat_q) begin
                  settleCnt_q <= '0;
                  state_q     <= ST_SCAN;
               end else if (dbCnt_q == DB_LAST) begin
                  valid_q   <= 1'b1;
                  keyCode_q <= keyCode(rowIdx_q, colIdx_q);
                  held_q    <= 1'b1;
                  state_q   <= ST_HELD;
               end else begin
                  dbCnt_q <= dbCntInc;
               end
            end

            ST_HELD: begin
               if (rowSync == 4'hF) begin
                  dbCnt_q <= '0;
                  state_q <= ST_RELEASE;
               end
            end

            ST_RELEASE: begin
               if (rowSync != 4'hF) begin
                  state_q <= ST_HELD;
               end else if (dbCnt_q == DB_LAST) begin
                  held_q      <= 1'b0;
                  settleCnt_q <= '0;
                  state_q     <= ST_SCAN;
               end else begin
                  dbCnt_q <= dbCntInc;
               end
            end

            default: begin
               state_q <= ST_SCAN;
            end
         endcase
      end
   end

   assign key_col      = colDrive(colIdx_q);
   assign keypad_input = keyCode_q;
   assign keypad_valid = valid_q;
   assign key_held     = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Drives a modelled 3x4 key matrix into keypad_scanner. Expected key codes
// are queued when a press is applied and matched against each strobe.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

   import keypad_pkg::*;

   localparam int DEBOUNCE = 20;
   localparam int SETTLE   = 3;
   // From reset release with the key already down on column 1: column 0 is
   // scanned first, column 1's window ends with the detection sample, and
   // the strobe follows DEBOUNCE cycles later.
   localparam int LATENCY_COL1 = 2 * SETTLE + DEBOUNCE;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  key_row;
   logic [2:0]  key_col;
   logic [3:0]  keypad_input;
   logic        keypad_valid;
   logic        key_held;

   logic [11:0] keysDown = '0;

   int          checks = 0;
   int          errors = 0;
   int          cycleCnt = 0;
   int          strobeCount = 0;
   int          lastStrobeCycle = 0;
   logic [3:0]  expQ[$];

   keypad_scanner #(
      .DEBOUNCE (DEBOUNCE),
      .SETTLE   (SETTLE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .key_row      (key_row),
      .key_col      (key_col),
      .keypad_input (keypad_input),
      .keypad_valid (keypad_valid),
      .key_held     (key_held)
   );

   always #5 clk = ~clk;

   // Key matrix: a pressed key at (r,c) pulls row r low while column c is driven low.
   always_comb begin
      key_row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (keysDown[r*3 + c] && (key_col[c] == 1'b0)) begin
               key_row[r] = 1'b0;
            end
         end
      end
   end

   function automatic logic [11:0] keyBit(input int r, input int c);
      return 12'b1 << (r*3 + c);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [11:0] keys, input int cycles);
      keysDown = keys;
      repeat (cycles) tick();
   endtask

   task automatic waitStrobe(input string tag, input int budget);
      int startCount;
      int n;
      startCount = strobeCount;
      n = 0;
      while ((strobeCount == startCount) && (n < budget)) begin
         tick();
         n++;
      end
      checkOutput(tag, 32'(strobeCount - startCount), 32'd1);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cycleCnt++;
      end
   end

   // Strobe monitor: every strobe must match the oldest queued expectation
   // and must never be high two cycles running.
   initial begin
      logic       prevValid;
      logic [3:0] expCode;
      prevValid = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && keypad_valid) begin
            strobeCount++;
            lastStrobeCycle = cycleCnt;
            checkOutput("strobe not back-to-back", 32'(prevValid), 32'd0);
            checkOutput("strobe was expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0) begin
               expCode = expQ.pop_front();
               checkOutput("strobe code", 32'(keypad_input), 32'(expCode));
            end
         end
         prevValid = keypad_valid;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int         relCycle;
      int         startCount;
      int         changes;
      logic [2:0] prevCol;

      // Test 1: '2' already down through reset, held steady.
      rst = 1'b1;
      keysDown = keyBit(0, 1);
      repeat (3) tick();
      checkOutput("reset key_col", 32'(key_col), 32'h6);
      checkOutput("reset keypad_input", 32'(keypad_input), 32'h0);
      checkOutput("reset keypad_valid", 32'(keypad_valid), 32'h0);
      checkOutput("reset key_held", 32'(key_held), 32'h0);

      startCount = strobeCount;
      expQ.push_back(4'h2);
      rst = 1'b0;
      relCycle = cycleCnt;
      waitStrobe("t1 strobe seen", 40);
      checkOutput("t1 latency", 32'(lastStrobeCycle - relCycle), 32'(LATENCY_COL1));
      checkOutput("t1 key_held", 32'(key_held), 32'd1);
      applyStimulus(keyBit(0, 1), 30);
      checkOutput("t1 single strobe", 32'(strobeCount - startCount), 32'd1);
      checkOutput("t1 still held", 32'(key_held), 32'd1);
      applyStimulus('0, 40);
      checkOutput("t1 released", 32'(key_held), 32'd0);

      // Test 2: '5' bouncing every 4 cycles, then steady.
      startCount = strobeCount;
      expQ.push_back(4'h5);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(((i % 2) == 0) ? keyBit(1, 1) : 12'h000, 4);
      end
      applyStimulus(keyBit(1, 1), 40);
      checkOutput("t2 single strobe", 32'(strobeCount - startCount), 32'd1);
      checkOutput("t2 keypad_input", 32'(keypad_input), 32'h5);
      applyStimulus('0, 40);
      checkOutput("t2 released", 32'(key_held), 32'd0);

      // Test 3: '9' shorter than the debounce window.
      startCount = strobeCount;
      applyStimulus(keyBit(2, 2), 10);
      applyStimulus('0, 30);
      checkOutput("t3 no strobe", 32'(strobeCount - startCount), 32'd0);
      checkOutput("t3 keypad_input kept", 32'(keypad_input), 32'h5);
      checkOutput("t3 key_held", 32'(key_held), 32'd0);
      changes = 0;
      prevCol = key_col;
      for (int i = 0; i < 3*SETTLE; i++) begin
         tick();
         if (key_col != prevCol) changes++;
         prevCol = key_col;
      end
      checkOutput("t3 scanning columns", 32'(changes), 32'd3);

      // Test 4: long '*' hold, bouncy release, then '#'.
      startCount = strobeCount;
      expQ.push_back(KEY_STAR);
      applyStimulus(keyBit(3, 0), 500);
      checkOutput("t4 star single strobe", 32'(strobeCount - startCount), 32'd1);
      checkOutput("t4 star keypad_input", 32'(keypad_input), 32'(KEY_STAR));
      for (int i = 0; i < 4; i++) begin
         applyStimulus(((i % 2) == 0) ? 12'h000 : keyBit(3, 0), 2);
      end
      applyStimulus('0, DEBOUNCE);
      checkOutput("t4 held during release debounce", 32'(key_held), 32'd1);
      applyStimulus('0, 5);
      checkOutput("t4 release accepted", 32'(key_held), 32'd0);
      checkOutput("t4 no strobe on bounce", 32'(strobeCount - startCount), 32'd1);
      expQ.push_back(KEY_HASH);
      keysDown = keyBit(3, 2);
      waitStrobe("t4 hash strobe seen", 60);
      checkOutput("t4 hash keypad_input", 32'(keypad_input), 32'(KEY_HASH));
      applyStimulus('0, 40);
      checkOutput("t4 hash released", 32'(key_held), 32'd0);

      // Test 5: '1' and '4' together, then '4' let go.
      startCount = strobeCount;
      applyStimulus(keyBit(0, 0) | keyBit(1, 0), 60);
      checkOutput("t5 no strobe on two rows", 32'(strobeCount - startCount), 32'd0);
      checkOutput("t5 key_held", 32'(key_held), 32'd0);
      expQ.push_back(4'h1);
      keysDown = keyBit(0, 0);
      waitStrobe("t5 strobe after release of 4", 60);
      checkOutput("t5 keypad_input", 32'(keypad_input), 32'h1);
      applyStimulus('0, 40);

      // Test 6: reset in the middle of debouncing '0'.
      rst = 1'b1;
      keysDown = keyBit(3, 1);
      tick();
      rst = 1'b0;
      startCount = strobeCount;
      repeat (2*SETTLE + 10) tick();
      rst = 1'b1;
      #1;
      checkOutput("t6 rst key_col", 32'(key_col), 32'h6);
      checkOutput("t6 rst keypad_input", 32'(keypad_input), 32'h0);
      checkOutput("t6 rst keypad_valid", 32'(keypad_valid), 32'h0);
      checkOutput("t6 rst key_held", 32'(key_held), 32'h0);
      repeat (3) tick();
      checkOutput("t6 no strobe across rst", 32'(strobeCount - startCount), 32'd0);
      expQ.push_back(4'h0);
      rst = 1'b0;
      relCycle = cycleCnt;
      waitStrobe("t6 strobe after rst", 40);
      checkOutput("t6 latency", 32'(lastStrobeCycle - relCycle), 32'(LATENCY_COL1));
      checkOutput("t6 key_held", 32'(key_held), 32'd1);
      applyStimulus('0, 40);
      checkOutput("t6 released", 32'(key_held), 32'd0);

      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
